// File: rtl/gauss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gauss_pkg : binomial coefficients, normalisation shift, fill FSM type |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gauss_pkg;

  localparam int FILL_CNT_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } fill_state_t;

  function automatic int coef(input int ksize, input int k);
    int c;
    c = 0;
    if (ksize == 5) begin
      case (k)
        0, 4:    c = 1;
        1, 3:    c = 4;
        2:       c = 6;
        default: c = 0;
      endcase
    end else begin
      case (k)
        0, 2:    c = 1;
        1:       c = 2;
        default: c = 0;
      endcase
    end
    return c;
  endfunction

  // Sum of the 2-D kernel is 2^norm_shift, so this shift normalises it.
  function automatic int norm_shift(input int ksize);
    return 2 * (ksize - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_window_filter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gauss_window_filter_if : column input / smoothed beat output streams  |
// | Optional: GAUSS_BYPASS_EN adds the bypass strobe        Rev 1.0       |
// +----------------------------------------------------------------------+
interface gauss_window_filter_if #(
  parameter int PIX_W = 8,
  parameter int ROWS  = 9,
  parameter int KSIZE = 3
);
  localparam int OUTS = ROWS - KSIZE + 1;

  logic                    col_valid;
  logic                    col_ready;
  logic                    frame_start;
  logic [ROWS*PIX_W-1:0]   col_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTS*PIX_W-1:0]   gauss_out;
`ifdef GAUSS_BYPASS_EN
  logic                    bypass;
`endif

  modport master (
`ifdef GAUSS_BYPASS_EN
    output bypass,
`endif
    output col_valid, frame_start, col_in, out_ready,
    input  col_ready, out_valid, gauss_out
  );

  modport slave (
`ifdef GAUSS_BYPASS_EN
    input  bypass,
`endif
    input  col_valid, frame_start, col_in, out_ready,
    output col_ready, out_valid, gauss_out
  );

endinterface
`default_nettype wire

// File: rtl/gauss_vsum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gauss_vsum : registered vertical binomial pass over one input column  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gauss_vsum
  import gauss_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ROWS  = 9,
  parameter int KSIZE = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [ROWS*PIX_W-1:0]                     col_in,
  output logic [(ROWS-KSIZE+1)*(PIX_W+KSIZE-1)-1:0] vsum
);

  localparam int OUTS = ROWS - KSIZE + 1;
  localparam int VW   = PIX_W + KSIZE - 1;

  logic [VW-1:0] w_sum [OUTS];

  always_comb begin
    for (int j = 0; j < OUTS; j++) begin
      w_sum[j] = '0;
      for (int k = 0; k < KSIZE; k++) begin
        w_sum[j] = w_sum[j] + VW'(coef(KSIZE, k)) * VW'(col_in[(j+k)*PIX_W +: PIX_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsum <= '0;
    end else if (en) begin
      for (int j = 0; j < OUTS; j++) begin
        vsum[j*VW +: VW] <= w_sum[j];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gauss_window_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gauss_window_filter : streaming separable binomial smoothing stage    |
// | Optional: GAUSS_BYPASS_EN (raw centre-pixel bypass)     Rev 1.0       |
// +----------------------------------------------------------------------+
module gauss_window_filter
  import gauss_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ROWS  = 9,
  parameter int KSIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  gauss_window_filter_if.slave  bus
);

  localparam int OUTS   = ROWS - KSIZE + 1;
  localparam int NORM_S = norm_shift(KSIZE);
  localparam int VW     = PIX_W + NORM_S / 2;
  localparam int HW     = PIX_W + NORM_S;
  localparam int CTR    = (KSIZE - 1) / 2;
  localparam logic [FILL_CNT_W-1:0] KCNT = FILL_CNT_W'(KSIZE);
  localparam logic [HW-1:0]         RND  = HW'(1) << (NORM_S - 1);

  generate
    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
      $error("gauss_window_filter: KSIZE must be 3 or 5");
    end
  endgenerate

  logic w_en;
  logic w_accept;

  // Downstream stall freezes the whole pipeline, input side included.
  assign w_en          = !(bus.out_valid && !bus.out_ready);
  assign bus.col_ready = w_en;
  assign w_accept      = bus.col_valid && w_en;

  fill_state_t             r_state;
  fill_state_t             w_state_nx;
  logic [FILL_CNT_W-1:0]   r_fill_cnt;
  logic [FILL_CNT_W-1:0]   w_fill_cnt_nx;
  logic                    w_col_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_fill_cnt <= w_fill_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_fill_cnt_nx = r_fill_cnt;
    w_col_full    = 1'b0;
    if (w_accept) begin
      if (bus.frame_start || r_state == EMPTY) begin
        w_state_nx    = FILL;
        w_fill_cnt_nx = FILL_CNT_W'(1);
      end else begin
        case (r_state)
          FILL: begin
            w_fill_cnt_nx = r_fill_cnt + FILL_CNT_W'(1);
            if (r_fill_cnt == KCNT - FILL_CNT_W'(1)) begin
              w_state_nx = RUN;
              w_col_full = 1'b1;
            end
          end
          RUN: begin
            w_col_full = 1'b1;
          end
          default: begin
            w_state_nx    = EMPTY;
            w_fill_cnt_nx = '0;
          end
        endcase
      end
    end
  end

  logic [OUTS*VW-1:0] w_vsum;

  gauss_vsum #(
    .PIX_W (PIX_W),
    .ROWS  (ROWS),
    .KSIZE (KSIZE)
  ) u_vsum (
    .clk    (clk),
    .rst    (rst),
    .en     (w_accept),
    .col_in (bus.col_in),
    .vsum   (w_vsum)
  );

  // Full-window tags travel with the column; stale window data never surfaces.
  logic                  r_s1_valid;
  logic                  r_s1_full;
  logic                  r_s2_full;
  logic                  r_out_valid;
  logic [OUTS*PIX_W-1:0] r_gauss;
  logic [VW-1:0]         r_win [KSIZE][OUTS];
  logic [HW-1:0]         w_h   [OUTS];
  logic [PIX_W-1:0]      w_pix [OUTS];

`ifdef GAUSS_BYPASS_EN
  localparam int RAW_D = KSIZE - CTR;

  logic [PIX_W-1:0] r_s1_raw [OUTS];
  logic [PIX_W-1:0] r_raw    [RAW_D][OUTS];
  logic             r_s1_byp;
  logic             r_s2_byp;

  // Shadow holds only slots CTR..KSIZE-1; index 0 is the window centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_byp <= 1'b0;
      r_s2_byp <= 1'b0;
      for (int j = 0; j < OUTS; j++) begin
        r_s1_raw[j] <= '0;
        for (int i = 0; i < RAW_D; i++) begin
          r_raw[i][j] <= '0;
        end
      end
    end else if (w_en) begin
      if (w_accept) begin
        r_s1_byp <= bus.bypass;
        for (int j = 0; j < OUTS; j++) begin
          r_s1_raw[j] <= bus.col_in[(j+CTR)*PIX_W +: PIX_W];
        end
      end
      if (r_s1_valid) begin
        r_s2_byp <= r_s1_byp;
        for (int i = 0; i < RAW_D - 1; i++) begin
          r_raw[i] <= r_raw[i+1];
        end
        r_raw[RAW_D-1] <= r_s1_raw;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_full   <= 1'b0;
      r_s2_full   <= 1'b0;
      r_out_valid <= 1'b0;
      r_gauss     <= '0;
      for (int c = 0; c < KSIZE; c++) begin
        for (int j = 0; j < OUTS; j++) begin
          r_win[c][j] <= '0;
        end
      end
    end else if (w_en) begin
      r_s1_valid  <= w_accept;
      r_s1_full   <= w_accept && w_col_full;
      r_s2_full   <= r_s1_valid && r_s1_full;
      r_out_valid <= r_s2_full;
      if (r_s1_valid) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          r_win[c] <= r_win[c+1];
        end
        for (int j = 0; j < OUTS; j++) begin
          r_win[KSIZE-1][j] <= w_vsum[j*VW +: VW];
        end
      end
      if (r_s2_full) begin
        for (int j = 0; j < OUTS; j++) begin
          r_gauss[j*PIX_W +: PIX_W] <= w_pix[j];
        end
      end
    end
  end

  // Rounding bias seeds the accumulator; the top PIX_W bits are the result.
  always_comb begin
    for (int j = 0; j < OUTS; j++) begin
      w_h[j] = RND;
      for (int c = 0; c < KSIZE; c++) begin
        w_h[j] = w_h[j] + HW'(coef(KSIZE, c)) * HW'(r_win[c][j]);
      end
      w_pix[j] = w_h[j][NORM_S +: PIX_W];
`ifdef GAUSS_BYPASS_EN
      if (r_s2_byp) begin
        w_pix[j] = r_raw[0][j];
      end
`endif
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.gauss_out = r_gauss;

endmodule
`default_nettype wire

// File: tb/tb_gauss_window_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gauss_window_filter : directed stimulus, 2-D convolution model     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_gauss_window_filter;

  localparam int P = 8;
  localparam int R = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gauss_window_filter_if #(.PIX_W(P), .ROWS(R), .KSIZE(3)) b3 ();
  gauss_window_filter_if #(.PIX_W(P), .ROWS(R), .KSIZE(5)) b5 ();

  gauss_window_filter #(.PIX_W(P), .ROWS(R), .KSIZE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  gauss_window_filter #(.PIX_W(P), .ROWS(R), .KSIZE(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5.slave)
  );

`ifdef GAUSS_BYPASS_EN
  initial begin
    b3.bypass = 1'b0;
    b5.bypass = 1'b0;
  end
`endif

  typedef struct {
    logic [71:0] data;
    int          due;
  } beat_t;

  beat_t q3[$];
  beat_t q5[$];
  int    win_m [2][5][9];
  int    cnt_m [2];
  int    bin   [2][5] = '{'{1, 2, 1, 0, 0}, '{1, 4, 6, 4, 1}};
  int    cyc   = 0;
  int    tests = 0;
  int    fails = 0;
  int    hs3   = 0;

  // Direct 2-D convolution of the model window with rounding.
  function automatic logic [71:0] model_beat(input int d);
    int          k;
    int          s;
    int          acc;
    logic [31:0] px;
    logic [71:0] b;
    k = (d == 0) ? 3 : 5;
    s = 2 * (k - 1);
    b = '0;
    for (int j = 0; j < R - k + 1; j++) begin
      acc = 0;
      for (int c = 0; c < k; c++)
        for (int r = 0; r < k; r++)
          acc += bin[d][c] * bin[d][r] * win_m[d][c][j+r];
      px = 32'((acc + (1 << (s - 1))) >> s);
      b[j*8 +: 8] = px[7:0];
    end
    return b;
  endfunction

  task automatic model_accept(input int d, input logic [71:0] col, input logic fs);
    int    k;
    beat_t e;
    k = (d == 0) ? 3 : 5;
    cnt_m[d] = fs ? 1 : ((cnt_m[d] < k) ? cnt_m[d] + 1 : k);
    for (int c = 0; c < k - 1; c++)
      for (int r = 0; r < R; r++)
        win_m[d][c][r] = win_m[d][c+1][r];
    for (int r = 0; r < R; r++)
      win_m[d][k-1][r] = int'(col[r*8 +: 8]);
    if (cnt_m[d] >= k) begin
      e.data = model_beat(d);
      e.due  = cyc + 2;
      if (d == 0) q3.push_back(e);
      else        q5.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q3.delete();
      q5.delete();
      cnt_m[0] = 0;
      cnt_m[1] = 0;
    end else begin
      if (b3.out_valid && !b3.out_ready) begin
        foreach (q3[i]) q3[i].due++;
      end else if (b3.out_valid) begin
        hs3++;
        if (q3.size() > 0) q3.delete(0);
      end
      if (b5.out_valid && !b5.out_ready) begin
        foreach (q5[i]) q5[i].due++;
      end else if (b5.out_valid && q5.size() > 0) begin
        q5.delete(0);
      end
      if (b3.col_valid && b3.col_ready) model_accept(0, b3.col_in, b3.frame_start);
      if (b5.col_valid && b5.col_ready) model_accept(1, b5.col_in, b5.frame_start);
    end
  end

  task automatic check(input int d);
    logic        ev;
    logic        av;
    logic [71:0] ed;
    logic [71:0] ad;
    if (d == 0) begin
      ev = (q3.size() > 0) && (q3[0].due <= cyc);
      ed = ev ? q3[0].data : '0;
      av = b3.out_valid;
      ad = {16'b0, b3.gauss_out};
    end else begin
      ev = (q5.size() > 0) && (q5[0].due <= cyc);
      ed = ev ? q5[0].data : '0;
      av = b5.out_valid;
      ad = {32'b0, b5.gauss_out};
    end
    tests++;
    if (av !== ev) begin
      fails++;
      $display("FAIL out_valid k%0d cyc %0d: got %0b want %0b", (d == 0) ? 3 : 5, cyc, av, ev);
    end else if (ev) begin
      tests++;
      if (ad !== ed) begin
        fails++;
        $display("FAIL gauss_out k%0d cyc %0d: got %h want %h", (d == 0) ? 3 : 5, cyc, ad, ed);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      check(0);
      check(1);
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] flat(input int v);
    logic [71:0] c;
    logic [31:0] vv;
    vv = 32'(v);
    for (int r = 0; r < R; r++) c[r*8 +: 8] = vv[7:0];
    return c;
  endfunction

  function automatic logic [71:0] imp(input int row, input int v);
    logic [71:0] c;
    logic [31:0] vv;
    vv = 32'(v);
    c = '0;
    c[row*8 +: 8] = vv[7:0];
    return c;
  endfunction

  function automatic logic [71:0] ramp(input int i);
    logic [71:0] c;
    logic [31:0] vv;
    for (int r = 0; r < R; r++) begin
      vv = 32'(r * 13 + i * 29 + 5);
      c[r*8 +: 8] = vv[7:0];
    end
    return c;
  endfunction

  task automatic drive(input int d, input logic vld, input logic [71:0] col, input logic fs);
    if (d == 0) begin
      b3.col_valid = vld; b3.col_in = col; b3.frame_start = fs;
    end else begin
      b5.col_valid = vld; b5.col_in = col; b5.frame_start = fs;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [71:0] col, input logic fs);
    int   n;
    logic rdy;
    n = 0;
    drive(d, 1'b1, col, fs);
    do begin
      @(posedge clk);
      n++;
      rdy = (d == 0) ? b3.col_ready : b5.col_ready;
    end while (!rdy && n < 64);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout k%0d: got col_ready=0 want 1 within 64 cycles", (d == 0) ? 3 : 5);
    end
    #1;
    drive(d, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] saved;
    int          h0;
    int          n;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    b3.out_ready = 1'b1;
    b5.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("reset_valid", b3.out_valid, 0);
    chk("reset_out", b3.gauss_out, 0);
    rst = 1'b0;
    step(1);
    chk("reset_ready", b3.col_ready, 1);

    // Uniform 100, latency 2
    repeat (3) send(0, flat(100), 1'b0);
    step(1);
    chk("uniform_lat1", b3.out_valid, 0);
    step(1);
    chk("uniform_valid", b3.out_valid, 1);
    chk("uniform_data", b3.gauss_out, {7{8'd100}});
    send(0, flat(100), 1'b0);
    send(0, flat(50), 1'b0);
    send(0, flat(50), 1'b0);
    step(4);

    // Frame restart followed by an impulse
    send(0, flat(0), 1'b1);
    send(0, imp(4, 255), 1'b0);
    step(2);
    chk("restart_hold", b3.out_valid, 0);
    send(0, flat(0), 1'b0);
    step(2);
    chk("impulse_valid", b3.out_valid, 1);
    chk("impulse_data", b3.gauss_out, 56'h00_00_20_40_20_00_00);
    step(4);

    // Backpressure: 6 columns, 3-cycle stall at first beat
    h0 = hs3;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, ramp(i), (i == 0));
      end
      begin
        n = 0;
        while (!b3.out_valid && n < 40) begin
          step(1);
          n++;
        end
        chk("bp_first_valid", b3.out_valid, 1);
        b3.out_ready = 1'b0;
        saved = b3.gauss_out;
        for (int i = 0; i < 3; i++) begin
          step(1);
          chk("bp_col_ready", b3.col_ready, 0);
          chk("bp_valid_hold", b3.out_valid, 1);
          chk("bp_data_hold", b3.gauss_out, saved);
        end
        b3.out_ready = 1'b1;
      end
    join
    step(6);
    chk("bp_beats", hs3 - h0, 4);

    // Reset during a stall
    send(0, flat(77), 1'b1);
    send(0, flat(77), 1'b0);
    send(0, flat(77), 1'b0);
    step(2);
    chk("stall_valid", b3.out_valid, 1);
    b3.out_ready = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_stall_valid", b3.out_valid, 0);
    chk("rst_stall_out", b3.gauss_out, 0);
    chk("rst_stall_ready", b3.col_ready, 1);
    rst = 1'b0;
    b3.out_ready = 1'b1;
    send(0, flat(30), 1'b0);
    send(0, flat(30), 1'b0);
    step(3);
    chk("refill_idle", b3.out_valid, 0);
    send(0, flat(30), 1'b0);
    step(2);
    chk("refill_valid", b3.out_valid, 1);
    chk("refill_data", b3.gauss_out, {7{8'd30}});
    step(3);

    // KSIZE=5 instance
    for (int i = 0; i < 5; i++) send(1, flat(200), (i == 0));
    step(1);
    chk("k5_lat1", b5.out_valid, 0);
    step(1);
    chk("k5_uniform_valid", b5.out_valid, 1);
    chk("k5_uniform_data", b5.gauss_out, {5{8'd200}});
    send(1, flat(0), 1'b1);
    send(1, flat(0), 1'b0);
    send(1, imp(4, 255), 1'b0);
    send(1, flat(0), 1'b0);
    send(1, flat(0), 1'b0);
    step(2);
    chk("k5_impulse_valid", b5.out_valid, 1);
    chk("k5_impulse_data", b5.gauss_out, 40'h06_18_24_18_06);

    step(6);
    chk("q3_drained", q3.size(), 0);
    chk("q5_drained", q5.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
